// File: rtl/spi_quad_target_if.sv
// Pad-side SPI pins plus the byte-stream handshake between the SPI target and its command decoder.
// The DUT side uses the slave modport; a bench or pad model drives through master.
interface spi_quad_target_if;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic [3:0] spi_mosi;
    logic [3:0] spi_miso;
    logic [3:0] spi_miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_underrun;
    logic       frame_abort;
    logic       busy;

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_valid,
        output spi_miso, spi_miso_oe, rx_data, rx_valid, rx_first,
               tx_ready, tx_underrun, frame_abort, busy
    );

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_valid,
        input  spi_miso, spi_miso_oe, rx_data, rx_valid, rx_first,
               tx_ready, tx_underrun, frame_abort, busy
    );
endinterface

// File: rtl/spi_quad_target.sv
// Oversampled mode-0 SPI target, 1/2/4 lanes: edges act 3 clk after the pad, rx_valid and tx_ready
// strike together one clk after the final beat; rx has no backpressure, a missing tx byte sends TX_IDLE.
module spi_quad_target #(
    parameter int         LANES   = 4,
    parameter logic [7:0] TX_IDLE = 8'hFF
) (
    input logic             clk,
    input logic             rst,
    spi_quad_target_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    localparam int         BEATS     = 8 / LANES;
    localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);
    localparam logic [3:0] LANE_MASK = 4'((1 << LANES) - 1);

    state_t           state, state_nxt;
    logic             sclk_s1, sclk_s2, sclk_d;
    logic             cs_s1, cs_s2, cs_d;
    logic [LANES-1:0] mosi_s1, mosi_s2;
    logic [2:0]       beat_cnt;
    logic [7:0]       rx_sh, tx_sh, rx_next, tx_byte, rx_data_r;
    logic [3:0]       miso_r, oe_r;
    logic             first_pending, rx_valid_r, rx_first_r, abort_r;
    logic             sclk_rise, cs_fall, cs_rise, beat_last, tx_ready_c;

    // cs_n flops come out of reset high so a released reset never fakes a frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_d  <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_d    <= 1'b1;
            mosi_s1 <= '0;
            mosi_s2 <= '0;
        end else begin
            sclk_s1 <= bus.spi_sclk;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            cs_s1   <= bus.spi_cs_n;
            cs_s2   <= cs_s1;
            cs_d    <= cs_s2;
            mosi_s1 <= bus.spi_mosi[LANES-1:0];
            mosi_s2 <= mosi_s1;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_d;
    assign cs_fall   = ~cs_s2 & cs_d;
    assign cs_rise   = cs_s2 & ~cs_d;
    assign beat_last = (beat_cnt == LAST_BEAT);
    assign rx_next   = 8'({rx_sh, mosi_s2});
    assign tx_byte   = bus.tx_valid ? bus.tx_data : TX_IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        tx_ready_c = 1'b0;
        case (state)
            IDLE:  if (cs_fall) state_nxt = LOAD;
            LOAD: begin
                tx_ready_c = 1'b1;
                state_nxt  = cs_rise ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (cs_rise)                     state_nxt = IDLE;
                else if (sclk_rise && beat_last) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // miso_r holds the beat launched after each sclk rise, so the byte-boundary reload of
    // tx_sh does not disturb the last beat before the master samples it on the fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sh         <= '0;
            tx_sh         <= '0;
            miso_r        <= '0;
            oe_r          <= '0;
            beat_cnt      <= '0;
            first_pending <= 1'b0;
            rx_data_r     <= '0;
            rx_valid_r    <= 1'b0;
            rx_first_r    <= 1'b0;
            abort_r       <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            rx_first_r <= 1'b0;
            abort_r    <= 1'b0;
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (cs_fall) first_pending <= 1'b1;
                end
                LOAD: begin
                    if (cs_rise) begin
                        tx_sh         <= '0;
                        miso_r        <= '0;
                        oe_r          <= '0;
                        first_pending <= 1'b0;
                    end else begin
                        tx_sh <= tx_byte;
                        oe_r  <= LANE_MASK;
                        if (first_pending) miso_r <= 4'(tx_byte[7 -: LANES]);
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        rx_sh  <= rx_next;
                        miso_r <= 4'(tx_sh[7 -: LANES]);
                        tx_sh  <= tx_sh << LANES;
                        if (beat_last) begin
                            rx_data_r     <= rx_next;
                            rx_valid_r    <= 1'b1;
                            rx_first_r    <= first_pending;
                            first_pending <= 1'b0;
                            beat_cnt      <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 3'd1;
                        end
                    end
                    if (cs_rise) begin
                        tx_sh         <= '0;
                        miso_r        <= '0;
                        oe_r          <= '0;
                        beat_cnt      <= '0;
                        first_pending <= 1'b0;
                        abort_r       <= sclk_rise ? !beat_last : (beat_cnt != 3'd0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.spi_miso    = miso_r;
    assign bus.spi_miso_oe = oe_r;
    assign bus.rx_data     = rx_data_r;
    assign bus.rx_valid    = rx_valid_r;
    assign bus.rx_first    = rx_first_r;
    assign bus.tx_ready    = tx_ready_c;
    assign bus.tx_underrun = tx_ready_c & ~bus.tx_valid;
    assign bus.frame_abort = abort_r;
    assign bus.busy        = (state != IDLE);
endmodule
